retire_trap_ctrl: RTL and testbench

- Sits between the writeback/retire stage and the simulation monitor.
- Watches retired instructions; on ebreak, an illegal instruction or a retire-watchdog timeout it freezes the pipeline, waits a programmable drain window so that in-flight memory writes complete, then drives a single-cycle ebreak pulse into the monitor together with a latched halt code.
- Keeps retired-instruction and cycle counters for difftest and performance logging.

---
 rtl/retire_trap_ctrl_pkg.sv | 18 +
 rtl/retire_trap_ctrl_cnt.sv | 27 ++
 rtl/retire_trap_ctrl.sv | 140 ++++++++++++++
 tb/tb_retire_trap_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_trap_ctrl_pkg.sv
// Shared types and constants for the retire trap controller.
package retire_trap_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } trap_state_t;

    localparam logic [7:0]  HALT_CODE_ILLEGAL = 8'hFE;
    localparam logic [7:0]  HALT_CODE_WDT     = 8'hFF;
    localparam logic [31:0] EBREAK_INSN       = 32'h0010_0073;

    function automatic logic is_ebreak_insn(input logic [31:0] insn);
        return insn == EBREAK_INSN;
    endfunction

endpackage

// File: rtl/retire_trap_ctrl_cnt.sv
// Generic counter with clear, load and enable; counts up or down.
module trap_cnt_wrap #(
    parameter int CNT_W = 64,
    parameter bit DOWN  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    output logic [CNT_W-1:0] cnt
);

    // Priority: clear over load over count
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (ld)
            cnt <= ld_val;
        else if (en)
            cnt <= DOWN ? cnt - 1'b1 : cnt + 1'b1;
    end

endmodule

// File: rtl/retire_trap_ctrl.sv
// Retire-stage trap controller: freezes on ebreak/illegal/watchdog, drains,
// then pulses ebreak to the monitor with a latched halt code.
//
// state | meaning
// RUN   | retiring normally, counters and watchdog live
// DRAIN | pipeline frozen, waiting for in-flight writes
// HALT  | ebreak delivered, everything frozen until rst
module retire_trap_ctrl
    import retire_trap_ctrl_pkg::*;
#(
    parameter int DATA_LEN     = 32,
    parameter int CNT_W        = 64,
    parameter int DRAIN_CYCLES = 2,
    parameter int WDT_LIMIT    = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                retire_valid,
    input  logic [DATA_LEN-1:0] retire_pc,
    input  logic                retire_is_ebreak,
    input  logic                retire_illegal,
    input  logic [DATA_LEN-1:0] retire_a0,
    output logic                stall_req,
    output logic                ebreak,
    output logic [7:0]          halt_code,
    output logic [DATA_LEN-1:0] halt_pc,
    output logic                halted,
    output logic [CNT_W-1:0]    inst_cnt,
    output logic [CNT_W-1:0]    cycle_cnt
);

    localparam int WDT_W = $clog2(WDT_LIMIT + 1);
    localparam int DRN_W = $clog2(DRAIN_CYCLES + 2);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_LIMIT - 1);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES);

    trap_state_t         state_q, state_d;
    logic [WDT_W-1:0]    wdt_cnt;
    logic [DRN_W-1:0]    drn_cnt;
    logic                in_run, in_drain, trap;
    logic [7:0]          code_d;
    logic [DATA_LEN-1:0] pc_d;
    logic                unused_a0;

    assign in_run    = (state_q == RUN);
    assign in_drain  = (state_q == DRAIN);
    assign stall_req = !in_run;
    assign halted    = (state_q == HALT);
    // Only the low byte of a0 forms the exit code
    assign unused_a0 = ^retire_a0[DATA_LEN-1:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            halt_code <= '0;
            halt_pc   <= '0;
        end else begin
            state_q   <= state_d;
            halt_code <= code_d;
            halt_pc   <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = halt_code;
        pc_d    = halt_pc;
        trap    = 1'b0;
        ebreak  = 1'b0;
        case (state_q)
            RUN: begin
                if (retire_valid && retire_is_ebreak) begin
                    trap   = 1'b1;
                    code_d = retire_a0[7:0];
                    pc_d   = retire_pc;
                end else if (retire_valid && retire_illegal) begin
                    trap   = 1'b1;
                    code_d = HALT_CODE_ILLEGAL;
                    pc_d   = retire_pc;
                end else if (!retire_valid && wdt_cnt == WDT_LAST) begin
                    trap   = 1'b1;
                    code_d = HALT_CODE_WDT;
                    pc_d   = '0;
                end
                if (trap)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (drn_cnt == '0) begin
                    ebreak  = 1'b1;
                    state_d = HALT;
                end
            end
            HALT: state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    trap_cnt_wrap #(.CNT_W(CNT_W), .DOWN(1'b0)) u_inst_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (in_run && retire_valid),
        .clr    (1'b0),
        .ld     (1'b0),
        .ld_val ('0),
        .cnt    (inst_cnt)
    );

    trap_cnt_wrap #(.CNT_W(CNT_W), .DOWN(1'b0)) u_cycle_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (state_q != HALT),
        .clr    (1'b0),
        .ld     (1'b0),
        .ld_val ('0),
        .cnt    (cycle_cnt)
    );

    // Watchdog runs only in RUN; any retire or trap resets the idle streak
    trap_cnt_wrap #(.CNT_W(WDT_W), .DOWN(1'b0)) u_wdt_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (1'b1),
        .clr    (!in_run || retire_valid || trap),
        .ld     (1'b0),
        .ld_val ('0),
        .cnt    (wdt_cnt)
    );

    trap_cnt_wrap #(.CNT_W(DRN_W), .DOWN(1'b1)) u_drn_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (in_drain && drn_cnt != '0),
        .clr    (1'b0),
        .ld     (trap),
        .ld_val (DRN_LOAD),
        .cnt    (drn_cnt)
    );

endmodule

// File: tb/tb_retire_trap_ctrl.sv
// Self-checking bench for retire_trap_ctrl: vector table, corner sequences
// and randomized retire streams checked against a behavioural model.
module tb_retire_trap_ctrl;

    localparam int DL = 32;
    localparam int CW = 64;
    localparam int D  = 2;
    localparam int W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic retire_valid = 1'b0, retire_is_ebreak = 1'b0, retire_illegal = 1'b0;
    logic [DL-1:0] retire_pc = '0, retire_a0 = '0;

    logic          stall_req, ebreak, halted;
    logic [7:0]    halt_code;
    logic [DL-1:0] halt_pc;
    logic [CW-1:0] inst_cnt, cycle_cnt;

    logic          z_stall_req, z_ebreak, z_halted;
    logic [7:0]    z_halt_code;
    logic [DL-1:0] z_halt_pc;
    logic [CW-1:0] z_inst_cnt, z_cycle_cnt;

    retire_trap_ctrl #(.DATA_LEN(DL), .CNT_W(CW), .DRAIN_CYCLES(D), .WDT_LIMIT(W)) dut (
        .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_is_ebreak(retire_is_ebreak), .retire_illegal(retire_illegal),
        .retire_a0(retire_a0), .stall_req(stall_req), .ebreak(ebreak),
        .halt_code(halt_code), .halt_pc(halt_pc), .halted(halted),
        .inst_cnt(inst_cnt), .cycle_cnt(cycle_cnt)
    );

    retire_trap_ctrl #(.DATA_LEN(DL), .CNT_W(CW), .DRAIN_CYCLES(0), .WDT_LIMIT(W)) dut0 (
        .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_is_ebreak(retire_is_ebreak), .retire_illegal(retire_illegal),
        .retire_a0(retire_a0), .stall_req(z_stall_req), .ebreak(z_ebreak),
        .halt_code(z_halt_code), .halt_pc(z_halt_pc), .halted(z_halted),
        .inst_cnt(z_inst_cnt), .cycle_cnt(z_cycle_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: remembers the edge on which the trap happened and
    // derives drain/halt phases from the distance to that edge.
    int            m_edge, m_trap_edge, m_idle;
    bit            m_trapped;
    logic [CW-1:0] m_inst, m_cycle;
    logic [7:0]    m_code;
    logic [DL-1:0] m_pc;

    task automatic model_reset();
        m_edge = 0; m_trap_edge = 0; m_idle = 0; m_trapped = 1'b0;
        m_inst = '0; m_cycle = '0; m_code = '0; m_pc = '0;
    endtask

    task automatic model_trap(input logic [7:0] code, input logic [DL-1:0] pc);
        m_trapped = 1'b1; m_trap_edge = m_edge; m_code = code; m_pc = pc;
    endtask

    task automatic model_edge();
        m_edge++;
        if (!m_trapped) begin
            m_cycle++;
            if (retire_valid) begin
                m_inst++;
                m_idle = 0;
                if (retire_is_ebreak) model_trap(retire_a0[7:0], retire_pc);
                else if (retire_illegal) model_trap(8'hFE, retire_pc);
            end else begin
                m_idle++;
                if (m_idle == W) model_trap(8'hFF, '0);
            end
        end else if (m_edge - 1 - m_trap_edge <= D) begin
            m_cycle++;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_stall"},  64'(stall_req), 64'(m_trapped));
        chk({tag, "_ebreak"}, 64'(ebreak), 64'(m_trapped && (m_edge - m_trap_edge == D)));
        chk({tag, "_halted"}, 64'(halted), 64'(m_trapped && (m_edge - m_trap_edge > D)));
        chk({tag, "_code"},   64'(halt_code), 64'(m_code));
        chk({tag, "_pc"},     64'(halt_pc), 64'(m_pc));
        chk({tag, "_inst"},   inst_cnt, m_inst);
        chk({tag, "_cycle"},  cycle_cnt, m_cycle);
    endtask

    task automatic step(input logic v, input logic eb, input logic il,
                        input logic [DL-1:0] pc, input logic [DL-1:0] a0);
        retire_valid = v; retire_is_ebreak = eb; retire_illegal = il;
        retire_pc = pc; retire_a0 = a0;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        retire_valid = 1'b0; retire_is_ebreak = 1'b0; retire_illegal = 1'b0;
        retire_pc = '0; retire_a0 = '0;
        #1;
        chk({tag, "_rst_stall"},  64'(stall_req), 64'd0);
        chk({tag, "_rst_ebreak"}, 64'(ebreak), 64'd0);
        chk({tag, "_rst_halted"}, 64'(halted), 64'd0);
        chk({tag, "_rst_code"},   64'(halt_code), 64'd0);
        chk({tag, "_rst_pc"},     64'(halt_pc), 64'd0);
        chk({tag, "_rst_inst"},   inst_cnt, 64'd0);
        chk({tag, "_rst_cycle"},  cycle_cnt, 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk({tag, "_rst_no_ebreak"}, 64'(ebreak), 64'd0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic          v, eb, il;
        logic [DL-1:0] pc, a0;
        logic          x_stall, x_ebreak, x_halted;
        logic [7:0]    x_code;
        logic [DL-1:0] x_pc;
        logic [CW-1:0] x_inst;
    } vec_t;

    vec_t tbl [10];
    int   pulses;
    int   burst;

    initial begin
        for (int i = 0; i < 5; i++)
            tbl[i] = '{1'b1, 1'b0, 1'b0, 32'h8000_0000 + 32'(4 * i), 32'(i + 1),
                       1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 64'(i + 1)};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'h0000_0000,
                   1'b1, 1'b0, 1'b0, 8'h00, 32'h8000_0010, 64'd6};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h8000_0014, 32'h0000_0055,
                   1'b1, 1'b0, 1'b0, 8'h00, 32'h8000_0010, 64'd6};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 32'h8000_0018, 32'h0000_0055,
                   1'b1, 1'b1, 1'b0, 8'h00, 32'h8000_0010, 64'd6};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0,
                   1'b1, 1'b0, 1'b1, 8'h00, 32'h8000_0010, 64'd6};
        tbl[9] = '{1'b1, 1'b0, 1'b1, 32'h8000_0099, 32'h0,
                   1'b1, 1'b0, 1'b1, 8'h00, 32'h8000_0010, 64'd6};

        do_reset("init");
        pulses = 0;
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].eb, tbl[i].il, tbl[i].pc, tbl[i].a0);
            chk($sformatf("tbl%0d_stall", i),  64'(stall_req), 64'(tbl[i].x_stall));
            chk($sformatf("tbl%0d_ebreak", i), 64'(ebreak), 64'(tbl[i].x_ebreak));
            chk($sformatf("tbl%0d_halted", i), 64'(halted), 64'(tbl[i].x_halted));
            chk($sformatf("tbl%0d_code", i),   64'(halt_code), 64'(tbl[i].x_code));
            chk($sformatf("tbl%0d_pc", i),     64'(halt_pc), 64'(tbl[i].x_pc));
            chk($sformatf("tbl%0d_inst", i),   inst_cnt, tbl[i].x_inst);
            if (ebreak) pulses++;
        end
        chk("tbl_pulse_count", 64'(pulses), 64'd1);

        // ebreak and illegal in the same retire: ebreak wins, low byte of a0
        do_reset("prio");
        step(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h1);
        step(1'b1, 1'b1, 1'b1, 32'h8000_0020, 32'h0000_0123);
        chk("prio_code", 64'(halt_code), 64'h23);
        chk("prio_pc", 64'(halt_pc), 64'h8000_0020);
        check_model("prio_t");
        repeat (4) begin
            step(1'b0, 1'b0, 1'b0, '0, '0);
            check_model("prio");
        end

        // illegal instruction trap
        do_reset("ill");
        step(1'b1, 1'b0, 1'b1, 32'h8000_0040, 32'h7);
        chk("ill_code", 64'(halt_code), 64'hFE);
        chk("ill_pc", 64'(halt_pc), 64'h8000_0040);
        repeat (4) begin
            step(1'b0, 1'b0, 1'b0, '0, '0);
            check_model("ill");
        end

        // watchdog trips on the 16th consecutive idle cycle
        do_reset("wdt");
        repeat (W - 1) step(1'b0, 1'b0, 1'b0, '0, '0);
        chk("wdt_pre_stall", 64'(stall_req), 64'd0);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        chk("wdt_stall", 64'(stall_req), 64'd1);
        chk("wdt_code", 64'(halt_code), 64'hFF);
        chk("wdt_pc", 64'(halt_pc), 64'd0);
        chk("wdt_inst", inst_cnt, 64'd0);
        repeat (4) begin
            step(1'b0, 1'b0, 1'b0, '0, '0);
            check_model("wdt");
        end

        // asynchronous reset in the middle of the drain window
        do_reset("mid");
        step(1'b1, 1'b1, 1'b0, 32'h8000_0100, 32'h77);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        check_model("mid_pre");
        #2;
        do_reset("mid");
        step(1'b0, 1'b0, 1'b0, '0, '0);
        check_model("mid_post");
        chk("mid_cycle_restart", cycle_cnt, 64'd1);

        // zero-length drain: ebreak right after the trap edge
        do_reset("d0");
        step(1'b1, 1'b1, 1'b0, 32'h8000_0200, 32'h42);
        chk("d0_ebreak", 64'(z_ebreak), 64'd1);
        chk("d0_stall", 64'(z_stall_req), 64'd1);
        chk("d0_halted_early", 64'(z_halted), 64'd0);
        chk("d0_code", 64'(z_halt_code), 64'h42);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        chk("d0_ebreak_off", 64'(z_ebreak), 64'd0);
        chk("d0_halted", 64'(z_halted), 64'd1);
        chk("d0_inst", z_inst_cnt, 64'd1);

        // randomized retire streams against the model
        for (int r = 0; r < 10; r++) begin
            do_reset("rnd");
            burst = 0;
            for (int c = 0; c < 80; c++) begin
                logic v, eb, il;
                if (burst == 0 && $urandom_range(99) < 4)
                    burst = $urandom_range(20, 8);
                if (burst > 0) begin
                    burst--;
                    v = 1'b0;
                end else begin
                    v = ($urandom_range(99) < 75);
                end
                eb = ($urandom_range(99) < 3);
                il = ($urandom_range(99) < 3);
                step(v, eb, il, $urandom(), $urandom());
                check_model($sformatf("rnd%0d_c%0d", r, c));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
